// File: rtl/uart_pkg.sv
// Shared types and baud-divider arithmetic for the uart_8n1 serial front end.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // Clocks per bit, rounded to nearest.
  function automatic int calc_div(input int clk_freq, input int uart_freq);
    return (clk_freq + uart_freq / 2) / uart_freq;
  endfunction

  function automatic int calc_half(input int div);
    return div / 2;
  endfunction

endpackage

// File: rtl/uart_8n1_if.sv
// Byte-side handshake between uart_8n1 and its host (dbgu32).
interface uart_8n1_if;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_error;
  logic       tx_write;
  logic [7:0] tx_data;
  logic       tx_finished;

  modport master (
    output tx_write, tx_data,
    input  rx_ready, rx_data, rx_error, tx_finished
  );

  modport slave (
    input  tx_write, tx_data,
    output rx_ready, rx_data, rx_error, tx_finished
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Loadable down-counter that stops at zero; zero flags the end of a bit period.
module uart_bit_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/uart_8n1.sv
// Full-duplex 8N1 UART: independent RX and TX FSMs, each paced by its own bit timer.
module uart_8n1
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 12000000,
  parameter int UART_FREQ = 115200
) (
  input  logic      clk,
  input  logic      n_reset,
  input  logic      rx,
  output logic      tx,
  uart_8n1_if.slave bus
);

  localparam int DIV  = calc_div(CLK_FREQ, UART_FREQ);
  localparam int HALF = calc_half(DIV);
  localparam int CW   = $clog2(DIV);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  localparam longint ACTUAL = longint'(DIV) * longint'(UART_FREQ);
  localparam longint DEV    = (ACTUAL > longint'(CLK_FREQ)) ? ACTUAL - longint'(CLK_FREQ)
                                                            : longint'(CLK_FREQ) - ACTUAL;

  if (DIV < 4) begin : g_div_too_small
    $fatal(1, "uart_8n1: clocks per bit must be at least 4");
  end
  if (DEV * 64'sd50 >= longint'(CLK_FREQ)) begin : g_baud_error
    $fatal(1, "uart_8n1: baud rounding error is 2 percent or more");
  end

  // RX synchroniser, preset to the idle level
  logic rx_m, rx_s;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      {rx_s, rx_m} <= 2'b11;
    end else begin
      {rx_s, rx_m} <= {rx_m, rx};
    end
  end

  rx_state_t     rx_state, rx_state_nx;
  logic          rx_load;
  logic [CW-1:0] rx_load_val;
  logic          rx_zero;
  logic          rx_shift_en;
  logic          rx_ready_nx, rx_error_nx;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic          rx_ready_q, rx_error_q;
  logic [7:0]    rx_data_q;

  uart_bit_timer #(.W(CW)) u_rx_timer (
    .clk    (clk),
    .n_reset(n_reset),
    .load   (rx_load),
    .value  (rx_load_val),
    .zero   (rx_zero)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rx_state <= RX_IDLE;
    end else begin
      rx_state <= rx_state_nx;
    end
  end

  always_comb begin
    rx_state_nx = rx_state;
    rx_load     = 1'b0;
    rx_load_val = DIV_M1;
    rx_shift_en = 1'b0;
    rx_ready_nx = 1'b0;
    rx_error_nx = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_load     = 1'b1;
          rx_load_val = HALF_M1;
          rx_state_nx = RX_START;
        end
      end
      RX_START: begin
        // Mid-start sample: a high line means the edge was only a glitch
        if (rx_zero) begin
          if (rx_s) begin
            rx_state_nx = RX_IDLE;
          end else begin
            rx_load     = 1'b1;
            rx_state_nx = RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (rx_zero) begin
          rx_load     = 1'b1;
          rx_shift_en = 1'b1;
          if (rx_idx == 3'd7) begin
            rx_state_nx = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (rx_zero) begin
          if (rx_s) begin
            rx_ready_nx = 1'b1;
            rx_state_nx = RX_IDLE;
          end else begin
            rx_error_nx = 1'b1;
            rx_state_nx = RX_WAIT;
          end
        end
      end
      RX_WAIT: begin
        if (rx_s) begin
          rx_state_nx = RX_IDLE;
        end
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rx_idx     <= 3'd0;
      rx_ready_q <= 1'b0;
      rx_error_q <= 1'b0;
      rx_data_q  <= 8'h00;
    end else begin
      rx_ready_q <= rx_ready_nx;
      rx_error_q <= rx_error_nx;
      if (rx_state == RX_START) begin
        rx_idx <= 3'd0;
      end else if (rx_shift_en) begin
        rx_idx <= rx_idx + 3'd1;
      end
      if (rx_ready_nx) begin
        rx_data_q <= rx_shift;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rx_shift_en) begin
      rx_shift <= {rx_s, rx_shift[7:1]};
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.rx_error = rx_error_q;
  assign bus.rx_data  = rx_data_q;

  tx_state_t  tx_state, tx_state_nx;
  logic       tx_load;
  logic       tx_zero;
  logic       tx_latch;
  logic       tx_adv;
  logic       tx_nx;
  logic       tx_finished_c;
  logic [2:0] tx_idx;
  logic [7:0] tx_shift;

  uart_bit_timer #(.W(CW)) u_tx_timer (
    .clk    (clk),
    .n_reset(n_reset),
    .load   (tx_load),
    .value  (DIV_M1),
    .zero   (tx_zero)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      tx_state <= TX_IDLE;
    end else begin
      tx_state <= tx_state_nx;
    end
  end

  // tx_shift[0] always holds the bit currently on the line during DATA
  always_comb begin
    tx_state_nx   = tx_state;
    tx_load       = 1'b0;
    tx_latch      = 1'b0;
    tx_adv        = 1'b0;
    tx_nx         = tx;
    tx_finished_c = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        if (bus.tx_write) begin
          tx_latch    = 1'b1;
          tx_load     = 1'b1;
          tx_nx       = 1'b0;
          tx_state_nx = TX_START;
        end
      end
      TX_START: begin
        if (tx_zero) begin
          tx_load     = 1'b1;
          tx_nx       = tx_shift[0];
          tx_state_nx = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_zero) begin
          tx_load = 1'b1;
          if (tx_idx == 3'd7) begin
            tx_nx       = 1'b1;
            tx_state_nx = TX_STOP;
          end else begin
            tx_nx  = tx_shift[1];
            tx_adv = 1'b1;
          end
        end
      end
      TX_STOP: begin
        if (tx_zero) begin
          tx_finished_c = 1'b1;
          tx_state_nx   = TX_IDLE;
        end
      end
      default: tx_state_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      tx     <= 1'b1;
      tx_idx <= 3'd0;
    end else begin
      tx <= tx_nx;
      if (tx_latch) begin
        tx_idx <= 3'd0;
      end else if (tx_adv) begin
        tx_idx <= tx_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tx_latch) begin
      tx_shift <= bus.tx_data;
    end else if (tx_adv) begin
      tx_shift <= {1'b0, tx_shift[7:1]};
    end
  end

  assign bus.tx_finished = tx_finished_c;

endmodule

// File: tb/tb_uart_8n1.sv
// Scoreboard bench for uart_8n1: stimulus queues expected bytes, monitors decode and compare.
`timescale 1ns/1ps
module tb_uart_8n1;

  localparam int DIV    = 104;
  localparam int HALF   = 52;
  localparam int RX_LAT = 3 + HALF + 9 * DIV;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cyc;
  } rx_exp_t;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic rx = 1'b1;
  logic tx;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   done = 0;

  rx_exp_t    rxq[$];
  logic [7:0] txq[$];
  rx_exp_t    mon_e;

  uart_8n1_if bus();

  uart_8n1 #(.CLK_FREQ(12000000), .UART_FREQ(115200)) dut (
    .clk    (clk),
    .n_reset(n_reset),
    .rx     (rx),
    .tx     (tx),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge: tx_write high for exactly one cycle.
  task automatic tx_send(input logic [7:0] d, input bit accepted);
    bus.tx_write = 1'b1;
    bus.tx_data  = d;
    if (accepted) txq.push_back(d);
    @(negedge clk);
    bus.tx_write = 1'b0;
  endtask

  // Called at a negedge: one frame, each bit exactly DIV clocks.
  task automatic rx_send(input logic [7:0] d, input logic stop, input logic [7:0] held);
    rx_exp_t e;
    e.err  = !stop;
    e.data = stop ? d : held;
    e.cyc  = cyc + RX_LAT;
    rxq.push_back(e);
    rx = 1'b0;
    tick(DIV);
    for (int b = 0; b < 8; b++) begin
      rx = d[b];
      tick(DIV);
    end
    rx = stop;
    tick(DIV);
  endtask

  // RX monitor
  always @(negedge clk) begin
    if (bus.rx_ready === 1'b1 || bus.rx_error === 1'b1) begin
      if (rxq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_unexpected ready=%0b error=%0b data=%02h required=no_pulse (cycle %0d)",
                 bus.rx_ready, bus.rx_error, bus.rx_data, cyc);
      end else begin
        mon_e = rxq.pop_front();
        check("rx_kind", 32'({bus.rx_error, bus.rx_ready}), mon_e.err ? 32'd2 : 32'd1);
        check("rx_data", 32'(bus.rx_data), 32'(mon_e.data));
        check("rx_latency", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  // TX monitor: decodes the serial line cycle by cycle
  initial begin
    logic [9:0] bits;
    bit bad;
    bit aborted;
    forever begin
      @(negedge clk);
      if (n_reset === 1'b1 && tx === 1'b0) begin
        bad = 0;
        aborted = 0;
        bits = '0;
        for (int i = 0; i < 10 * DIV; i++) begin
          if (i > 0) @(negedge clk);
          if (n_reset !== 1'b1) begin
            aborted = 1;
            break;
          end
          if (i % DIV == 0) bits[i / DIV] = tx;
          else if (tx !== bits[i / DIV]) bad = 1;
          if (bus.tx_finished !== (i == 10 * DIV - 1)) bad = 1;
        end
        if (!aborted) begin
          check("tx_framing", 32'({bits[9], bits[0], bad}), 32'd4);
          if (txq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL tx_unexpected_frame actual=%02h required=no_frame", bits[8:1]);
          end else begin
            check("tx_byte", 32'(bits[8:1]), 32'(txq.pop_front()));
          end
        end
      end else if (bus.tx_finished === 1'b1) begin
        checks++;
        failures++;
        $display("FAIL tx_finished_stray actual=1 required=0 (cycle %0d)", cyc);
      end
    end
  end

  initial begin
    #(60000 * 10);
    if (!done) begin
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
    end
  end

  initial begin
    bit got;
    bus.tx_write = 1'b0;
    bus.tx_data  = 8'h00;

    // Reset values
    tick(5);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("rst_rx_error", 32'(bus.rx_error), 32'd0);
    check("rst_tx_finished", 32'(bus.tx_finished), 32'd0);
    check("rst_rx_data", 32'(bus.rx_data), 32'd0);
    n_reset = 1'b1;
    tick(10);

    // Full duplex: A5 out while 3C comes in
    fork
      tx_send(8'hA5, 1);
      rx_send(8'h3C, 1'b1, 8'h00);
    join
    tick(100);

    // Low stop bit followed by a long break, then a good byte
    rx_send(8'h55, 1'b0, 8'h3C);
    tick(3 * DIV);
    rx = 1'b1;
    tick(DIV);
    rx_send(8'h01, 1'b1, 8'h00);
    tick(100);

    // Short low glitch, then a real byte
    rx = 1'b0;
    tick(20);
    rx = 1'b1;
    tick(2 * DIV);
    rx_send(8'h7E, 1'b1, 8'h00);
    tick(100);

    // Write while busy is ignored; back-to-back write right after tx_finished
    tx_send(8'h11, 1);
    tick(299);
    tx_send(8'h22, 0);
    got = 0;
    for (int i = 0; i < 1200 && !got; i++) begin
      @(negedge clk);
      if (bus.tx_finished === 1'b1) got = 1;
    end
    check("tx_finished_seen", 32'(got), 32'd1);
    @(negedge clk);
    tx_send(8'h22, 1);
    check("tx_b2b_start", 32'(tx), 32'd0);
    tick(10 * DIV + 50);

    // Reset in the middle of a frame in both directions
    rx = 1'b0;
    tx_send(8'hF0, 0);
    tick(DIV - 1);
    rx = 1'b1;
    tick(2 * DIV);
    rx = 1'b0;
    tick(2 * DIV);
    @(posedge clk);
    #2 n_reset = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_tx_finished", 32'(bus.tx_finished), 32'd0);
    check("midrst_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("midrst_rx_error", 32'(bus.rx_error), 32'd0);
    rx = 1'b1;
    tick(3);
    check("midrst_rx_data", 32'(bus.rx_data), 32'd0);
    n_reset = 1'b1;
    tick(2 * DIV);
    fork
      tx_send(8'h5A, 1);
      rx_send(8'hC3, 1'b1, 8'h00);
    join
    tick(100);

    check("rx_queue_drained", 32'(rxq.size()), 32'd0);
    check("tx_queue_drained", 32'(txq.size()), 32'd0);
    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
